// File: rtl/loop_sequencer_pkg.sv
// Shared types and constants for the DECODE-loop sequencer and its loop stack.
package loop_sequencer_pkg;

    localparam int unsigned LOOP_VALUE_WIDTH = 18;
    localparam int unsigned LOOP_PC_WIDTH    = 16;
    localparam int unsigned LOOP_STEP_WIDTH  = 3;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_START = 2'd1,
        CMD_END   = 2'd2,
        CMD_ABORT = 2'd3
    } loop_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_APU_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [LOOP_VALUE_WIDTH-1:0] value;
        logic [LOOP_VALUE_WIDTH-1:0] remaining;
        logic                        independent;
        logic [LOOP_PC_WIDTH-1:0]    body_pc;
    } loop_entry_t;

    // Iterations one loop-end step may retire: min(remaining, width).
    function automatic logic [LOOP_STEP_WIDTH-1:0] clamp_step(
        input logic [LOOP_VALUE_WIDTH-1:0] remaining,
        input int unsigned                 width
    );
        if (remaining >= LOOP_VALUE_WIDTH'(width)) begin
            return LOOP_STEP_WIDTH'(width);
        end
        return LOOP_STEP_WIDTH'(remaining);
    endfunction

endpackage

// File: rtl/loop_sequencer_stack.sv
// Register stack of nested-loop entries; depth is a signed top index, -1 when empty.
module loop_stack
    import loop_sequencer_pkg::*;
#(
    parameter int unsigned LOG_LOOP_CNT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  loop_entry_t           push_entry,
    input  logic                  pop,
    input  logic                  write_top,
    input  loop_entry_t           write_entry,
    input  logic                  clear,
    output loop_entry_t           top_entry_c,
    output logic [LOG_LOOP_CNT:0] depth,
    output logic                  empty_c,
    output logic                  full_c
);

    localparam int unsigned LOOP_CNT = 1 << LOG_LOOP_CNT;
    localparam int unsigned DEPTH_W  = LOG_LOOP_CNT + 1;

    loop_entry_t             entries_q [LOOP_CNT];
    loop_entry_t             entries_d [LOOP_CNT];
    logic [DEPTH_W-1:0]      depth_q;
    logic [DEPTH_W-1:0]      depth_d;
    logic [LOG_LOOP_CNT-1:0] top_idx;
    logic [LOG_LOOP_CNT-1:0] push_idx;

    assign top_idx     = depth_q[LOG_LOOP_CNT-1:0];
    assign push_idx    = top_idx + LOG_LOOP_CNT'(1);
    assign empty_c     = depth_q[DEPTH_W-1];
    assign full_c      = (depth_q == DEPTH_W'(LOOP_CNT - 1));
    assign top_entry_c = entries_q[top_idx];
    assign depth       = depth_q;

    // Clear wins over push, push over pop, pop over an in-place top update.
    always_comb begin
        entries_d = entries_q;
        depth_d   = depth_q;
        if (clear) begin
            depth_d = '1;
            for (int unsigned i = 0; i < LOOP_CNT; i++) begin
                entries_d[i] = '0;
            end
        end else if (push && !full_c) begin
            entries_d[push_idx] = push_entry;
            depth_d             = depth_q + DEPTH_W'(1);
        end else if (pop && !empty_c) begin
            entries_d[top_idx] = '0;
            depth_d            = depth_q - DEPTH_W'(1);
        end else if (write_top && !empty_c) begin
            entries_d[top_idx] = write_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '1;
            for (int unsigned i = 0; i < LOOP_CNT; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            depth_q   <= depth_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Nested-loop sequencer for DECODE: executes loop commands, publishes value updates to the APU,
// and answers with jump/copy information. Define LOOP_SUPERSCALAR_EN to enable multi-iteration steps.
module loop_sequencer
    import loop_sequencer_pkg::*;
#(
    parameter int unsigned LOG_LOOP_CNT      = 2,
    parameter int unsigned SUPERSCALAR_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [LOOP_VALUE_WIDTH-1:0]        cmd_iterations,
    input  logic                               cmd_independent,
    input  logic [LOOP_PC_WIDTH-1:0]           cmd_body_pc,
    output logic                               apu_valid,
    input  logic                               apu_ready,
    output logic [LOG_LOOP_CNT-1:0]            apu_depth,
    output logic [LOOP_VALUE_WIDTH-1:0]        apu_value,
    output logic [LOOP_STEP_WIDTH-1:0]         apu_step,
    output logic                               resp_valid,
    output logic                               resp_taken,
    output logic [LOOP_PC_WIDTH-1:0]           resp_pc,
    output logic [LOOP_STEP_WIDTH-1:0]         resp_copies,
    output logic signed [LOG_LOOP_CNT:0]       loop_depth,
    output logic                               error
);

    localparam int unsigned VW     = LOOP_VALUE_WIDTH;
    localparam int unsigned STEP_W = LOOP_STEP_WIDTH;
    localparam int unsigned LW     = LOG_LOOP_CNT;

`ifdef LOOP_SUPERSCALAR_EN
    localparam bit SUPERSCALAR_EN = 1'b1;
`else
    localparam bit SUPERSCALAR_EN = 1'b0;
`endif

    seq_state_e             state_q, state_d;
    loop_cmd_e              cmd_op_q, cmd_op_d;
    logic [VW-1:0]          cmd_iter_q, cmd_iter_d;
    logic                   cmd_indep_q, cmd_indep_d;
    logic [LOOP_PC_WIDTH-1:0] cmd_pc_q, cmd_pc_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   apu_valid_q, apu_valid_d;
    logic [LW-1:0]          apu_depth_q, apu_depth_d;
    logic [VW-1:0]          apu_value_q, apu_value_d;
    logic [STEP_W-1:0]      apu_step_q, apu_step_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_taken_q, resp_taken_d;
    logic [LOOP_PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [STEP_W-1:0]      resp_copies_q, resp_copies_d;
    logic                   error_q, error_d;
    logic                   pend_pop_q, pend_pop_d;

    logic                   stack_push;
    logic                   stack_pop;
    logic                   stack_write;
    logic                   stack_clear;
    loop_entry_t            push_entry;
    loop_entry_t            write_entry;
    loop_entry_t            top_entry;
    logic [LW:0]            stack_depth;
    logic                   stack_empty;
    logic                   stack_full;

    logic [VW-1:0]          start_iters;
    logic [STEP_W-1:0]      end_step;
    logic [VW-1:0]          end_value;
    logic [VW-1:0]          end_remaining;
    logic                   end_taken;

    loop_stack #(
        .LOG_LOOP_CNT (LOG_LOOP_CNT)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push        (stack_push),
        .push_entry  (push_entry),
        .pop         (stack_pop),
        .write_top   (stack_write),
        .write_entry (write_entry),
        .clear       (stack_clear),
        .top_entry_c (top_entry),
        .depth       (stack_depth),
        .empty_c     (stack_empty),
        .full_c      (stack_full)
    );

    // A zero trip count runs the body once (and flags an error).
    assign start_iters   = (cmd_iter_q == '0) ? VW'(1) : cmd_iter_q;
    assign end_step      = top_entry.independent ?
                           clamp_step(top_entry.remaining, SUPERSCALAR_WIDTH) : STEP_W'(1);
    assign end_value     = top_entry.value + VW'(end_step);
    assign end_remaining = top_entry.remaining - VW'(end_step);
    assign end_taken     = (end_remaining != '0);

    assign push_entry  = '{value: '0, remaining: start_iters,
                           independent: cmd_indep_q, body_pc: cmd_pc_q};
    assign write_entry = '{value: end_value, remaining: end_remaining,
                           independent: top_entry.independent, body_pc: top_entry.body_pc};

    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_iter_d    = cmd_iter_q;
        cmd_indep_d   = cmd_indep_q;
        cmd_pc_d      = cmd_pc_q;
        cmd_ready_d   = cmd_ready_q;
        apu_valid_d   = apu_valid_q;
        apu_depth_d   = apu_depth_q;
        apu_value_d   = apu_value_q;
        apu_step_d    = apu_step_q;
        resp_valid_d  = resp_valid_q;
        resp_taken_d  = resp_taken_q;
        resp_pc_d     = resp_pc_q;
        resp_copies_d = resp_copies_q;
        error_d       = error_q;
        pend_pop_d    = pend_pop_q;
        stack_push    = 1'b0;
        stack_pop     = 1'b0;
        stack_write   = 1'b0;
        stack_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_op_d    = loop_cmd_e'(cmd_op);
                    cmd_iter_d  = cmd_iterations;
                    cmd_indep_d = cmd_independent & SUPERSCALAR_EN;
                    cmd_pc_d    = cmd_body_pc;
                    cmd_ready_d = 1'b0;
                    if (loop_cmd_e'(cmd_op) == CMD_NOP) begin
                        resp_valid_d  = 1'b1;
                        resp_taken_d  = 1'b0;
                        resp_copies_d = STEP_W'(1);
                        state_d       = ST_RESP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            // Stack update; error and abort paths skip the APU and respond directly.
            ST_EXEC: begin
                resp_taken_d  = 1'b0;
                resp_copies_d = STEP_W'(1);
                pend_pop_d    = 1'b0;
                resp_valid_d  = 1'b1;
                state_d       = ST_RESP;
                case (cmd_op_q)
                    CMD_START: begin
                        if (stack_full) begin
                            error_d = 1'b1;
                        end else begin
                            if (cmd_iter_q == '0) begin
                                error_d = 1'b1;
                            end
                            stack_push    = 1'b1;
                            apu_valid_d   = 1'b1;
                            apu_depth_d   = stack_depth[LW-1:0] + LW'(1);
                            apu_value_d   = '0;
                            apu_step_d    = '0;
                            resp_copies_d = cmd_indep_q ?
                                            clamp_step(start_iters, SUPERSCALAR_WIDTH) : STEP_W'(1);
                            resp_valid_d  = 1'b0;
                            state_d       = ST_APU_WAIT;
                        end
                    end
                    CMD_END: begin
                        if (stack_empty) begin
                            error_d = 1'b1;
                        end else begin
                            stack_write   = 1'b1;
                            apu_valid_d   = 1'b1;
                            apu_depth_d   = stack_depth[LW-1:0];
                            apu_value_d   = end_value;
                            apu_step_d    = end_step;
                            resp_taken_d  = end_taken;
                            resp_pc_d     = top_entry.body_pc;
                            resp_copies_d = (top_entry.independent && end_taken) ?
                                            clamp_step(end_remaining, SUPERSCALAR_WIDTH) : STEP_W'(1);
                            pend_pop_d    = !end_taken;
                            resp_valid_d  = 1'b0;
                            state_d       = ST_APU_WAIT;
                        end
                    end
                    CMD_ABORT: begin
                        stack_clear = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            ST_APU_WAIT: begin
                if (apu_ready) begin
                    apu_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end

            // A finished loop leaves the stack as the response retires.
            ST_RESP: begin
                resp_valid_d = 1'b0;
                stack_pop    = pend_pop_q;
                pend_pop_d   = 1'b0;
                cmd_ready_d  = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_op_q      <= CMD_NOP;
            cmd_iter_q    <= '0;
            cmd_indep_q   <= 1'b0;
            cmd_pc_q      <= '0;
            cmd_ready_q   <= 1'b1;
            apu_valid_q   <= 1'b0;
            apu_depth_q   <= '0;
            apu_value_q   <= '0;
            apu_step_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_pc_q     <= '0;
            resp_copies_q <= STEP_W'(1);
            error_q       <= 1'b0;
            pend_pop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_op_q      <= cmd_op_d;
            cmd_iter_q    <= cmd_iter_d;
            cmd_indep_q   <= cmd_indep_d;
            cmd_pc_q      <= cmd_pc_d;
            cmd_ready_q   <= cmd_ready_d;
            apu_valid_q   <= apu_valid_d;
            apu_depth_q   <= apu_depth_d;
            apu_value_q   <= apu_value_d;
            apu_step_q    <= apu_step_d;
            resp_valid_q  <= resp_valid_d;
            resp_taken_q  <= resp_taken_d;
            resp_pc_q     <= resp_pc_d;
            resp_copies_q <= resp_copies_d;
            error_q       <= error_d;
            pend_pop_q    <= pend_pop_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign apu_valid   = apu_valid_q;
    assign apu_depth   = apu_depth_q;
    assign apu_value   = apu_value_q;
    assign apu_step    = apu_step_q;
    assign resp_valid  = resp_valid_q;
    assign resp_taken  = resp_taken_q;
    assign resp_pc     = resp_pc_q;
    assign resp_copies = resp_copies_q;
    assign loop_depth  = stack_depth;
    assign error       = error_q;

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Owns the nested-loop stack for the control unit's DECODE loop. The control unit hands it decoded loop-start and loop-end instructions. It maintains per-depth loop value, remaining count and independence flag, and publishes each loop-variable change to the APU over a valid/ready handshake. It then tells the control unit whether to jump back to the loop body and how many superscalar copies the iteration represents.

## Interface
- LOG_LOOP_CNT, 2: log2 of stack depth; LOOP_CNT = 1 << LOG_LOOP_CNT.
- SUPERSCALAR_WIDTH, 4: maximum iterations retired per loop-end step (≥1).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both high.
- cmd_op  in  2  0 NOP, 1 START, 2 END, 3 ABORT.
- cmd_iterations  in  18  trip count (START only).
- cmd_independent  in  1  loop iterations may run superscalar (START only).
- cmd_body_pc  in  16  pc of first body instruction (START only).
- apu_valid / apu_ready  out / in  1 / 1  APU update handshake.
- apu_depth  out  LOG_LOOP_CNT  stack level updated.
- apu_value  out  18  new loop value.
- apu_step  out  3  increment applied (0 on START).
- resp_valid  out  1  one-cycle completion pulse.
- resp_taken  out  1  1: jump to resp_pc; 0: fall through.
- resp_pc  out  16  jump target.
- resp_copies  out  3  instruction-queue copy amount, 1..SUPERSCALAR_WIDTH.
- loop_depth  out  LOG_LOOP_CNT+1  signed top index; −1 = empty.
- error  out  1  sticky overflow/underflow/zero-trip flag.

## Operation
- FSM states: IDLE → EXEC → APU_WAIT → RESP → IDLE. cmd_ready is high only in IDLE.
- NOP: IDLE → RESP. resp_taken=0, resp_copies=1, no stack or APU activity.
- START:
  - In EXEC: depth+1, value=0, remaining=cmd_iterations, independent, body_pc stored.
  - APU receives (new depth, 0, 0).
  - resp_taken=0. resp_copies=min(remaining, SW) if independent, else 1.
- END:
  - step = independent ? min(remaining, SW) : 1. value += step; remaining −= step.
  - APU receives (depth, new value, step).
  - If remaining now 0, the entry pops in RESP with resp_taken=0. Otherwise resp_taken=1 and resp_pc=body_pc.
  - resp_copies = min(new remaining, SW) if independent and taken, else 1.
- ABORT: stack cleared to depth −1 in EXEC, no APU update. RESP with resp_taken=0.
- Boundaries:
  - START at depth LOOP_CNT−1: error=1, stack unchanged, no APU update.
  - END on empty stack: error=1, resp_taken=0, no APU update.
  - cmd_iterations=0: error=1, treated as 1.
  - Value arithmetic is 18-bit unsigned and wraps modulo 2^18. remaining never underflows because step ≤ remaining.
  - Popping depth 0 yields −1.

## Timing
- Reset values: loop_depth=−1, all stack entries zero, error=0, cmd_ready=1, apu_valid=0, resp_valid=0, resp_taken=0, resp_pc=0, resp_copies=1, apu_* fields=0, FSM=IDLE.
- Command accepted at edge T. Stack updated at T+1. apu_valid is high from T+1 until the edge where apu_ready=1. resp_valid pulses the cycle after that edge. cmd_ready is high again the cycle after resp_valid.
- Minimum turnaround with apu_ready tied high is 4 cycles from accept to next accept.
- apu_* and resp_* are stable while their valid is high.
- Reset mid-operation:
  - Stack is discarded and the FSM returns to IDLE next cycle.
  - A pending APU update is dropped; no resp_valid is issued.

## Configuration
- LOOP_SUPERSCALAR_EN defined: independent loops step by min(remaining, SUPERSCALAR_WIDTH) and resp_copies is computed as above.
- Undefined: cmd_independent is ignored and stored as 0. Step is always 1 and resp_copies is always 1. The SUPERSCALAR_WIDTH parameter is accepted but unused.

## Structure
- Shared control package holds:
  - loop_cmd_e enum (NOP/START/END/ABORT).
  - loop_entry_t struct {value[17:0], remaining[17:0], independent, body_pc[15:0]}.
  - Constant LOOP_VALUE_WIDTH=18.
- One sub-module, loop_stack: LOOP_CNT-entry register stack with push, pop, write-top and clear ports, exposing the top entry and depth.
- FSM, step arithmetic and handshakes live in loop_sequencer.

## Test plan
- START iter=3 indep=0, then END×3 with apu_ready=1:
  - APU values 0,1,2,3; resp_taken 0,1,1,0; loop_depth −1→0→0→0→−1; error=0.
- Macro on, START iter=10 indep=1, SW=4, END×3:
  - Steps 4,4,2; values 4,8,10; resp_copies 4,4,2→1; last END pops.
- Nested START(2), START(2), END, END, END, END:
  - Depth reaches 1; inner loop pops before outer; resp_pc matches each level's body_pc.
- Five STARTs with LOG_LOOP_CNT=2:
  - Fifth sets error=1, depth stays 3, no apu_valid.
  - Subsequent END on empty stack after ABORT keeps error=1 with resp_taken=0.
- apu_ready held low 5 cycles during END:
  - apu_valid and its fields hold steady, no resp_valid until handshake, cmd_ready low throughout.
- Reset asserted while in APU_WAIT:
  - Next cycle loop_depth=−1, apu_valid=0, cmd_ready=1, and no resp_valid ever pulses for that command.
